// File: rtl/stoch_ctrl_pkg.sv
// Shared definitions for the stochastic subtractor-matrix controller.
package stoch_ctrl_pkg;

  localparam int unsigned DefCntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRun,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/stoch_ones_counter.sv
// Counts the cycles in which bit_in is 1 while enabled; clr restarts from zero.
module stoch_ones_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count <= '0;
    end else if (en && bit_in) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stoch_sub_mat_ctrl.sv
// Sequences flush/run/done of an external stochastic subtractor matrix and
// accumulates per-element ones counts of its output bitstreams.
module stoch_sub_mat_ctrl
  import stoch_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 2,
  parameter int unsigned NUM_COLS = 2,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               start,
  input  logic                               abort,
  input  logic [CNT_W-1:0]                   len,
  input  logic [NUM_ROWS*NUM_COLS-1:0]       Y,
  output logic                               sub_nrst,
  output logic                               sample_en,
  output logic                               busy,
  output logic                               done,
  output logic [NUM_ROWS*NUM_COLS*CNT_W-1:0] counts
);

  localparam int unsigned NumElem = NUM_ROWS * NUM_COLS;

  ctrl_state_e      state_q;
  logic [CNT_W-1:0] rem_q;
  logic             cnt_clr;
  logic             cnt_en;

  // Counters restart on an accepted start and on an abort of an active run.
  assign cnt_clr = ((state_q == StIdle) && start) ||
                   (((state_q == StFlush) || (state_q == StRun)) && abort);
  assign cnt_en  = (state_q == StRun) && !abort;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      sub_nrst  <= 1'b0;
      sample_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StFlush;
            rem_q     <= len;
            sub_nrst  <= 1'b0;
            sample_en <= 1'b0;
            busy      <= 1'b1;
          end else begin
            sub_nrst  <= 1'b1;
            sample_en <= 1'b0;
            busy      <= 1'b0;
          end
        end
        StFlush: begin
          if (abort) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            sub_nrst  <= 1'b1;
            sample_en <= 1'b0;
            busy      <= 1'b0;
          end else if (rem_q == '0) begin
            state_q   <= StDone;
            sub_nrst  <= 1'b1;
            sample_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_q   <= StRun;
            sub_nrst  <= 1'b1;
            sample_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StRun: begin
          if (abort) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            sample_en <= 1'b0;
            busy      <= 1'b0;
          end else if (rem_q == CNT_W'(1)) begin
            state_q   <= StDone;
            rem_q     <= '0;
            sample_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            rem_q <= rem_q - CNT_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NumElem; k++) begin : g_cnt
    stoch_ones_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .bit_in(Y[k]),
      .count (counts[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_stoch_sub_mat_ctrl.sv
// Randomized self-checking bench: a cycle-timeline model of each run predicts
// the control outputs and the accumulated ones counts.
module tb_stoch_sub_mat_ctrl;

  localparam int unsigned NR = 2;
  localparam int unsigned NC = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned NE = NR * NC;

  logic               CLK = 1'b0;
  logic               RST;
  logic               start;
  logic               abort;
  logic [CW-1:0]      len;
  logic [NE-1:0]      Y;
  logic               sub_nrst;
  logic               sample_en;
  logic               busy;
  logic               done;
  logic [NE*CW-1:0]   counts;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  stoch_sub_mat_ctrl #(
    .NUM_ROWS(NR),
    .NUM_COLS(NC),
    .CNT_W   (CW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .abort    (abort),
    .len      (len),
    .Y        (Y),
    .sub_nrst (sub_nrst),
    .sample_en(sample_en),
    .busy     (busy),
    .done     (done),
    .counts   (counts)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_counts);
    check_eq({tag, ".sub_nrst"}, 32'(sub_nrst), 32'd1);
    check_eq({tag, ".sample_en"}, 32'(sample_en), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".counts"}, 32'(counts), exp_counts);
  endtask

  // ymode: 0 random, 1 constant 4'b0101, 2 element 0 alternates 1,0,1,...
  // abort_t: timeline cycle (1 = flush) in which abort is raised, -1 for none.
  task automatic do_run(input int l, input int abort_t, input int ymode, input bit noisy,
                        output logic [31:0] result);
    int            acc [NE];
    logic [NE-1:0] y;
    logic [31:0]   exp_counts;
    bit            in_run;
    for (int k = 0; k < NE; k++) acc[k] = 0;
    result = '0;
    start  = 1'b1;
    len    = CW'(l);
    Y      = NE'($urandom);
    tick();
    start  = 1'b0;
    for (int t = 1; t <= l + 2; t++) begin
      in_run = (t >= 2) && (t <= l + 1);
      check_eq("run.sub_nrst", 32'(sub_nrst), (t == 1) ? 32'd0 : 32'd1);
      check_eq("run.sample_en", 32'(sample_en), 32'(in_run));
      check_eq("run.busy", 32'(busy), 32'(t <= l + 1));
      check_eq("run.done", 32'(done), 32'(t == l + 2));
      if (t == l + 2) begin
        for (int k = 0; k < NE; k++) exp_counts[k*CW +: CW] = CW'(acc[k]);
        check_eq("run.counts", 32'(counts), exp_counts);
        result = counts;
      end
      y = NE'($urandom);
      if (ymode == 1) y = 4'b0101;
      if (ymode == 2) y[0] = ((t - 2) % 2 == 0);
      Y = y;
      if (in_run) begin
        for (int k = 0; k < NE; k++) acc[k] += int'(y[k]);
      end
      len   = CW'($urandom);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy && t == l + 2) start = 1'b1;
      abort = (t == abort_t) || (noisy && t == l + 2);
      tick();
      if (t == abort_t) begin
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort", 32'd0);
        return;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < NE; k++) exp_counts[k*CW +: CW] = CW'(acc[k]);
    check_idle("post", exp_counts);
    for (int i = 0; i < 3; i++) begin
      Y = NE'($urandom);
      tick();
    end
    check_idle("hold", exp_counts);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] res;
    RST   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    len   = '0;
    Y     = '0;
    tick();
    tick();
    check_eq("rst.sub_nrst", 32'(sub_nrst), 32'd0);
    check_eq("rst.sample_en", 32'(sample_en), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.counts", 32'(counts), 32'd0);
    RST = 1'b0;
    tick();
    check_idle("rst.first", 32'd0);

    // Nominal 2x2 run with constant 0101.
    do_run(8, -1, 1, 1'b0, res);
    check_eq("nominal", res, 32'h0008_0008);

    // Zero-length run goes flush -> done.
    do_run(0, -1, 0, 1'b0, res);
    check_eq("len0", res, 32'd0);

    // Abort in the third run cycle (timeline cycle 4), and on the last run cycle.
    do_run(8, 4, 1, 1'b0, res);
    do_run(5, 6, 1, 1'b0, res);
    do_run(6, 1, 0, 1'b0, res);

    // Start/len/abort noise while busy and in done must be ignored.
    do_run(7, -1, 0, 1'b1, res);
    do_run(4, -1, 0, 1'b0, res);

    // Long alternating run with mid-run len changes.
    do_run(255, -1, 2, 1'b1, res);
    check_eq("alt.elem0", 32'(res[CW-1:0]), 32'd128);

    for (int r = 0; r < 8; r++) begin
      do_run(int'($urandom_range(0, 20)), -1, 0, 1'($urandom_range(0, 1)), res);
    end
    do_run(12, int'($urandom_range(1, 13)), 0, 1'b0, res);

    // Reset mid-run kills the run without a done pulse.
    start = 1'b1;
    len   = CW'(8);
    Y     = '1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    RST = 1'b1;
    tick();
    check_eq("midrst.sub_nrst", 32'(sub_nrst), 32'd0);
    check_eq("midrst.sample_en", 32'(sample_en), 32'd0);
    check_eq("midrst.busy", 32'(busy), 32'd0);
    check_eq("midrst.done", 32'(done), 32'd0);
    check_eq("midrst.counts", 32'(counts), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    check_idle("midrst.first", 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("midrst.nodone", 32'(done), 32'd0);
    end
    do_run(3, -1, 0, 1'b0, res);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stoch_sub_mat_ctrl.md
STOCH_SUB_MAT_CTRL -- requirements
Module: stoch_sub_mat_ctrl

Interface
REQ-001 Parameter NUM_ROWS, default 2, rows of the controlled stochastic subtractor matrix.
REQ-002 Parameter NUM_COLS, default 2, columns of the controlled matrix.
REQ-003 Parameter CNT_W, default 16, width of the run-length register and of every per-element ones counter.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 abort  input  1  cancels an active run.
REQ-008 len  input  CNT_W  bitstream length in cycles; captured with an accepted start.
REQ-009 Y  input  NUM_ROWS*NUM_COLS  matrix-subtractor output bits, row-major, element (i,j) at bit i*NUM_COLS+j.
REQ-010 sub_nrst  output  1  active-low reset to the subtractor matrix.
REQ-011 sample_en  output  1  enable to the upstream bitstream generators.
REQ-012 busy  output  1  high in FLUSH and RUN.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 counts  output  NUM_ROWS*NUM_COLS*CNT_W  per-element ones counts, row-major, element k at bits [k*CNT_W +: CNT_W].

Function
REQ-015 The FSM SHALL have states IDLE, FLUSH, RUN and DONE; all outputs are registered, or decoded from the state register only (Moore).
REQ-016 IDLE: start=1 SHALL capture len into the remaining-cycle counter, clear all ones counters, and enter FLUSH.
REQ-017 FLUSH SHALL last exactly one cycle with sub_nrst=0 and sample_en=0, then enter RUN if captured len>0, otherwise DONE.
REQ-018 RUN SHALL last exactly len cycles with sub_nrst=1 and sample_en=1; in each RUN cycle, every counter whose Y bit is 1 SHALL increment by one.
REQ-019 After the last RUN cycle the FSM SHALL enter DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 counts SHALL hold their final values from DONE until the next accepted start; counts never exceed len, so no overflow can occur.
REQ-021 Latency: start accepted at edge k -> FLUSH in cycle k+1, RUN in cycles k+2..k+1+len, done=1 in cycle k+2+len.
REQ-022 start while busy or in DONE SHALL be ignored, and no request SHALL be queued.
REQ-023 abort=1 in FLUSH or RUN SHALL force IDLE on the next edge, clear all counters, and suppress done; abort in IDLE or DONE SHALL have no effect.
REQ-024 If abort and the final RUN cycle coincide, abort SHALL win.
REQ-025 A change on len outside the accepting cycle SHALL have no effect on a run in progress.
REQ-026 In IDLE and DONE, sub_nrst=1 and sample_en=0.

Reset
REQ-027 While RST=1 at a rising edge, the block SHALL enter IDLE and clear all counters and the remaining-cycle counter.
REQ-028 During reset, outputs SHALL be: sub_nrst=0, sample_en=0, busy=0, done=0, counts=0.
REQ-029 RST asserted mid-run SHALL terminate the run without a done pulse.
REQ-030 The first cycle after RST deasserts SHALL be IDLE with sub_nrst=1.

Structure
REQ-031 Shared package stoch_ctrl_pkg SHALL hold the FSM state enumeration and the default CNT_W constant.
REQ-032 Per-element counting SHALL be one sub-module, stoch_ones_counter (CLK, RST, clr, en, bit_in, count), instantiated NUM_ROWS*NUM_COLS times in a generate loop.
REQ-033 The matrix datapath SHALL NOT be instantiated inside this block; it is connected externally via sub_nrst, sample_en and Y.

Verification
REQ-034 Nominal run, 2x2, len=8, Y=4'b0101 constant -> done in cycle k+10; counts elements 0,2 = 8 and elements 1,3 = 0.
REQ-035 len=0 -> FLUSH then DONE; done in cycle k+2; sample_en never high; all counts = 0.
REQ-036 abort during the 3rd RUN cycle of a len=8 run -> IDLE next cycle; no done pulse; counts = 0.
REQ-037 start re-asserted during RUN and during DONE -> ignored; exactly one done pulse; a new start in IDLE afterwards begins a fresh run.
REQ-038 RST asserted mid-RUN, then released -> outputs at reset values; first post-reset cycle is IDLE with sub_nrst=1.
REQ-039 Alternating Y element 0 (1,0,1,0...), len=255 with CNT_W=8 -> count for element 0 = 128; len changed mid-run has no effect.
